// File: rtl/cam_frame_capture.sv
// rtl/cam_frame_capture.sv - OV7670 RGB565 pixel capture reduced to RGB111 frame-buffer writes
// Define CAM_TESTPATTERN_EN to replace camera data with 8 vertical colour bars.
module cam_frame_capture #(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int AW           = 15,
  parameter int DW           = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_pclk,
  input  logic          CAM_href,
  input  logic          CAM_vsync,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          overflow
);

  localparam int CW = $clog2(CAM_SCREEN_X + 1);
  localparam int RW = $clog2(CAM_SCREEN_Y + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(CAM_SCREEN_X);
  localparam logic [RW-1:0] ROW_MAX  = RW'(CAM_SCREEN_Y);
  localparam logic [AW-1:0] ROW_STEP = AW'(CAM_SCREEN_X);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LINE_IDLE  = 2'd1,
    BYTE_LO    = 2'd2
  } state_t;

  logic [1:0]    r_pclk_sync;
  logic [1:0]    r_href_sync;
  logic [1:0]    r_vsync_sync;
  logic [7:0]    r_data_sync1;
  logic [7:0]    r_data_sync2;
  logic          r_pclk_d;
  logic          r_href_d;
  logic          r_vsync_d;

  state_t        r_state;
  state_t        w_state_next;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_base;
  logic [7:0]    r_byte_hi;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_wr;
  logic          r_done;
  logic          r_ovf;

  logic          w_href;
  logic          w_cap;
  logic          w_href_ok;
  logic          w_href_fall;
  logic          w_vsync_rise;
  logic          w_vsync_fall;
  logic          w_frame_start;
  logic          w_frame_end;
  logic          w_latch_hi;
  logic          w_pixel;
  logic          w_line_end;
  logic          w_in_bounds;
  logic [DW-1:0] w_pixel_data;
  logic          w_unused;

  // Data bus is synchronized with the same depth as pclk so both arrive together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pclk_sync  <= '0;
      r_href_sync  <= '0;
      r_vsync_sync <= '0;
      r_data_sync1 <= '0;
      r_data_sync2 <= '0;
      r_pclk_d     <= 1'b0;
      r_href_d     <= 1'b0;
      r_vsync_d    <= 1'b0;
    end else begin
      r_pclk_sync  <= {r_pclk_sync[0], CAM_pclk};
      r_href_sync  <= {r_href_sync[0], CAM_href};
      r_vsync_sync <= {r_vsync_sync[0], CAM_vsync};
      r_data_sync1 <= CAM_px_data;
      r_data_sync2 <= r_data_sync1;
      r_pclk_d     <= r_pclk_sync[1];
      r_href_d     <= r_href_sync[1];
      r_vsync_d    <= r_vsync_sync[1];
    end
  end

  assign w_href       = r_href_sync[1];
  assign w_cap        = r_pclk_sync[1] & ~r_pclk_d;
  assign w_href_fall  = ~w_href & r_href_d;
  // Still accepts a capture in the cycle href is seen falling, so it is processed before line end.
  assign w_href_ok    = w_href | r_href_d;
  assign w_vsync_rise = r_vsync_sync[1] & ~r_vsync_d;
  assign w_vsync_fall = ~r_vsync_sync[1] & r_vsync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_FRAME;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    w_latch_hi    = 1'b0;
    w_pixel       = 1'b0;
    w_line_end    = 1'b0;
    case (r_state)
      WAIT_FRAME: begin
        if (w_vsync_fall) begin
          w_frame_start = 1'b1;
          w_state_next  = LINE_IDLE;
        end
      end
      LINE_IDLE: begin
        if (w_cap && w_href_ok && !w_href_fall) begin
          w_latch_hi   = 1'b1;
          w_state_next = BYTE_LO;
        end
        w_line_end = w_href_fall && (r_col != '0);
      end
      BYTE_LO: begin
        if (w_cap && w_href_ok) begin
          w_pixel      = 1'b1;
          w_state_next = LINE_IDLE;
        end else if (w_href_fall) begin
          w_state_next = LINE_IDLE;
        end
        w_line_end = w_href_fall && ((r_col != '0) || (w_cap && w_href_ok));
      end
      default: begin
        w_state_next = WAIT_FRAME;
      end
    endcase
    if ((r_state != WAIT_FRAME) && w_vsync_rise) begin
      w_frame_end  = 1'b1;
      w_latch_hi   = 1'b0;
      w_pixel      = 1'b0;
      w_line_end   = 1'b0;
      w_state_next = WAIT_FRAME;
    end
  end

  assign w_in_bounds = (r_col < COL_MAX) && (r_row < ROW_MAX);

`ifdef CAM_TESTPATTERN_EN
  localparam logic [CW-1:0] BAR_LAST = CW'(CAM_SCREEN_X / 8 - 1);

  logic [2:0]    r_bar;
  logic [CW-1:0] r_bar_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_frame_start || w_line_end) begin
      r_bar     <= '0;
      r_bar_cnt <= '0;
    end else if (w_pixel) begin
      if (r_bar_cnt == BAR_LAST) begin
        r_bar_cnt <= '0;
        r_bar     <= r_bar + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + CW'(1);
      end
    end
  end

  assign w_pixel_data = DW'(r_bar);
  assign w_unused     = ^r_byte_hi;
`else
  // Keep only the MSB of each colour field: R[4], G[5], B[4].
  assign w_pixel_data = DW'({r_byte_hi[7], r_byte_hi[2], r_data_sync2[4]});
  assign w_unused     = ^{r_byte_hi[6:3], r_byte_hi[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_base    <= '0;
      r_byte_hi <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_wr      <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= w_frame_end;
      if (w_frame_start) begin
        r_col  <= '0;
        r_row  <= '0;
        r_base <= '0;
        r_ovf  <= 1'b0;
      end
      if (w_latch_hi) begin
        r_byte_hi <= r_data_sync2;
      end
      if (w_pixel) begin
        if (w_in_bounds) begin
          r_addr <= r_base + AW'(r_col);
          r_data <= w_pixel_data;
          r_wr   <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
        if (r_col != COL_MAX) begin
          r_col <= r_col + CW'(1);
        end
      end
      // Later assignment wins: a pixel on the href-fall cycle is written before col clears.
      if (w_line_end) begin
        r_col <= '0;
        if (r_row != ROW_MAX) begin
          r_row  <= r_row + RW'(1);
          r_base <= r_base + ROW_STEP;
        end
      end
    end
  end

  assign mem_px_addr = r_addr;
  assign mem_px_data = r_data;
  assign px_wr       = r_wr;
  assign frame_done  = r_done;
  assign overflow    = r_ovf;

endmodule
